// File: rtl/keyevent_fifo.sv
// keyevent_fifo: PS/2 set-2 scan-code decoder with E0/F0 prefix tracking,
// prefix timeout recovery and a first-word-fall-through event FIFO.
// Event format: {ext, brk, code[7:0]}.
module keyevent_fifo #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000000,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    input  logic       i_evt_rd,
    output logic       o_evt_valid,
    output logic [9:0] o_evt,
    output logic [7:0] o_char,
    output logic       o_full,
    output logic       o_overflow,
    output logic       o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_E0   = 2'd1;
    localparam logic [1:0] S_F0   = 2'd2;
    localparam logic [1:0] S_E0F0 = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [7:0]            char_q, char_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH-1:0][9:0] mem_q, mem_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;

    logic                  emit;
    logic [9:0]            emit_evt;
    logic                  is_e0, is_f0;
    logic                  pop, push_ok, full;

    assign is_e0 = (i_byte == 8'hE0);
    assign is_f0 = (i_byte == 8'hF0);

    // Prefix FSM, timeout counter and event construction
    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
        err_d    = 1'b0;
        char_d   = char_q;
        emit     = 1'b0;
        emit_evt = '0;
        if (i_byte_en) begin
            // A byte always wins over a timeout expiring in the same cycle.
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_e0) begin
                        state_d = S_E0;
                    end else if (is_f0) begin
                        state_d = S_F0;
                    end else begin
                        emit     = 1'b1;
                        emit_evt = {2'b00, i_byte};
                        char_d   = i_byte;
                    end
                end
                S_E0: begin
                    if (is_f0) begin
                        state_d = S_E0F0;
                    end else if (!is_e0) begin
                        emit     = 1'b1;
                        emit_evt = {2'b10, i_byte};
                        state_d  = S_IDLE;
                    end
                end
                S_F0: begin
                    state_d = S_IDLE;
                    if (is_e0 || is_f0) begin
                        err_d = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_evt = {2'b01, i_byte};
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (is_e0 || is_f0) begin
                        err_d = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_evt = {2'b11, i_byte};
                    end
                end
            endcase
        end else if (state_q != S_IDLE && cnt_q == CW'(TIMEOUT)) begin
            // Truncated sequence: abandon the prefix.
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
    end

    assign full = (count_q == FULL_CNT);
    assign pop  = i_evt_rd && (count_q != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok = emit && (!full || pop);

    // FIFO storage, pointers, occupancy and sticky overflow
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q | (emit && full && !pop);
        if (push_ok) begin
            mem_d[wptr_q] = emit_evt;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            char_q  <= 8'h00;
            ovf_q   <= 1'b0;
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            char_q  <= char_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign o_evt_valid = (count_q != '0);
    assign o_evt       = o_evt_valid ? mem_q[rptr_q] : 10'h000;
    assign o_char      = char_q;
    assign o_full      = full;
    assign o_overflow  = ovf_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_keyevent_fifo.sv
// Directed bench for keyevent_fifo (DEPTH=4, TIMEOUT=20).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keyevent_fifo;

    logic       clk;
    logic       i_sclr;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       i_evt_rd;
    logic       o_evt_valid;
    logic [9:0] o_evt;
    logic [7:0] o_char;
    logic       o_full;
    logic       o_overflow;
    logic       o_err;

    int checks   = 0;
    int failures = 0;

    keyevent_fifo #(.DEPTH(4), .TIMEOUT(20)) dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .i_evt_rd    (i_evt_rd),
        .o_evt_valid (o_evt_valid),
        .o_evt       (o_evt),
        .o_char      (o_char),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sclr();
        i_sclr = 1'b1;
        @(negedge clk);
        i_sclr = 1'b0;
    endtask

    // One byte strobe; returns on the falling edge after it was captured.
    task automatic send(input logic [7:0] b, input logic rd);
        i_byte_en = 1'b1;
        i_byte    = b;
        i_evt_rd  = rd;
        @(negedge clk);
        i_byte_en = 1'b0;
        i_evt_rd  = 1'b0;
    endtask

    task automatic pop();
        i_evt_rd = 1'b1;
        @(negedge clk);
        i_evt_rd = 1'b0;
    endtask

    initial begin
        int npulse;
        i_sclr = 1'b1; i_byte_en = 1'b0; i_byte = 8'h00; i_evt_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_sclr = 1'b0;

        // Reset state
        check("rst_valid", o_evt_valid, 0);
        check("rst_full",  o_full,      0);
        check("rst_ovf",   o_overflow,  0);
        check("rst_err",   o_err,       0);
        check("rst_char",  o_char,      8'h00);
        check("rst_evt",   o_evt,       10'h000);

        // Make then break of 1C
        send(8'h1C, 1'b0);
        check("make_valid", o_evt_valid, 1);
        check("make_evt",   o_evt,       10'h01C);
        check("make_char",  o_char,      8'h1C);
        pop();
        check("make_pop_empty", o_evt_valid, 0);
        send(8'hF0, 1'b0);
        check("f0_no_evt", o_evt_valid, 0);
        send(8'h1C, 1'b0);
        check("brk_valid", o_evt_valid, 1);
        check("brk_evt",   o_evt,       10'h11C);
        pop();

        // Extended make and extended break; o_char untouched
        sclr();
        send(8'hE0, 1'b0);
        check("e0_no_evt", o_evt_valid, 0);
        send(8'h75, 1'b0);
        check("ext_make_evt", o_evt, 10'h275);
        check("ext_char",     o_char, 8'h00);
        pop();
        send(8'hE0, 1'b0);
        send(8'hE0, 1'b0);
        check("e0e0_no_err", o_err, 0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        check("ext_brk_evt", o_evt, 10'h375);
        check("ext_char2",   o_char, 8'h00);

        // Pop the queued event while the next is pushed
        send(8'h2A, 1'b1);
        check("pushpop_valid", o_evt_valid, 1);
        check("pushpop_evt",   o_evt,       10'h02A);
        pop();
        check("pushpop_empty", o_evt_valid, 0);

        // Fill, push+pop while full, then overflow
        sclr();
        send(8'h15, 1'b0);
        send(8'h1D, 1'b0);
        send(8'h24, 1'b0);
        check("fill3_full", o_full, 0);
        send(8'h2D, 1'b0);
        check("fill4_full", o_full, 1);
        check("fill4_ovf",  o_overflow, 0);
        check("fill4_head", o_evt, 10'h015);
        send(8'h2C, 1'b1);
        check("full_pp_full", o_full, 1);
        check("full_pp_ovf",  o_overflow, 0);
        check("full_pp_head", o_evt, 10'h01D);
        send(8'h35, 1'b0);
        check("ovf_set",  o_overflow, 1);
        check("ovf_head", o_evt, 10'h01D);
        check("drain0", o_evt, 10'h01D); pop();
        check("drain1_full", o_full, 0);
        check("drain1", o_evt, 10'h024); pop();
        check("drain2", o_evt, 10'h02D); pop();
        check("drain3", o_evt, 10'h02C); pop();
        check("drain_empty", o_evt_valid, 0);
        check("ovf_sticky",  o_overflow, 1);
        pop();
        check("rd_empty_ignored", o_evt_valid, 0);

        // Prefix timeout
        sclr();
        send(8'hF0, 1'b0);
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 5) check("to_not_early", o_err, 0);
            if (o_err) npulse++;
        end
        check("to_pulses",  npulse, 1);
        check("to_no_evt",  o_evt_valid, 0);
        send(8'h1C, 1'b0);
        check("to_then_make", o_evt, 10'h01C);
        pop();

        // F0 F0 protocol error
        send(8'hF0, 1'b0);
        send(8'hF0, 1'b0);
        check("f0f0_err",    o_err, 1);
        check("f0f0_no_evt", o_evt_valid, 0);
        @(negedge clk);
        check("f0f0_err_pulse", o_err, 0);

        // Clear mid-sequence discards the prefix
        send(8'hE0, 1'b0);
        sclr();
        send(8'h1C, 1'b0);
        check("sclr_prefix", o_evt, 10'h01C);

        // Clear with queued events and overflow
        send(8'h15, 1'b0);
        send(8'h1D, 1'b0);
        send(8'h24, 1'b0);
        send(8'h2D, 1'b0);
        check("pre_sclr_ovf", o_overflow, 1);
        sclr();
        check("sclr_valid", o_evt_valid, 0);
        check("sclr_ovf",   o_overflow, 0);
        check("sclr_full",  o_full, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
